mtr_drv_nch: RTL
================

// Module: mtr_drv_nch
// PURPOSE
//  Parametrised N-channel H-bridge PWM driver; successor to the fixed 2-channel 11-bit motor driver.
//  One shared free-running PWM counter drives per-channel duty comparators.
//  Duty and direction are double-buffered and updated only at period boundaries (glitch-free).
//  Each channel has a reversal dead-time FSM that holds both bridge legs low before the new direction drives.
// PARAMETERS
//  NUM_CH    2   number of motor channels
//  PWM_W     11  PWM resolution in bits; period = 2**PWM_W clocks
//  DEAD_CYC  32  clocks both outputs are held low after a direction reversal (1..2**PWM_W-1)
// PORTS
//  clk             in   1              system clock, all logic on posedge
//  rst             in   1              asynchronous, active-high reset
//  en              in   1              global drive enable; low forces all PWM outputs low
//  spd             in   NUM_CH*PWM_W   per-channel duty, channel i = spd[i*PWM_W +: PWM_W]
//  rev             in   NUM_CH         per-channel direction request, 1 = reverse
//  PWM_frwrd       out  NUM_CH         forward-leg PWM per channel
//  PWM_rev         out  NUM_CH         reverse-leg PWM per channel
//  rev_busy        out  NUM_CH         channel is in dead-time state
//  period_start    out  1              1-clock pulse, high in the cycle cnt==0
// BEHAVIOUR
//  - Reset: cnt=0, spd_q=0, dir_q=0 (forward), all FSMs in DRIVE, all outputs 0. Outputs clear
//    asynchronously on rst assertion. The first period after reset starts at cnt=0.
//  - cnt: PWM_W bits, increments every clock and wraps from 2**PWM_W-1 to 0. It is not gated by en.
//  - period_start: registered version of (cnt==2**PWM_W-1), so it is high exactly when cnt==0.
//    It is 0 during the first cnt==0 after reset.
//  - Shadow load: in the cycle cnt==2**PWM_W-1, spd_q[i]<=spd[i] and req_q[i]<=rev[i].
//    Changes at any other time have no effect until the next load. Loaded values apply from cnt==0.
//  - Duty: drv[i] = (cnt < spd_q[i]); outputs are registered, giving 1 clock latency from cnt.
//    spd=0 gives output never high.
//    spd=2**PWM_W-1 gives output high 2**PWM_W-1 of every 2**PWM_W clocks (100% is not reachable).
//  - FSM per channel, states DRIVE and DEAD:
//    DRIVE: PWM_frwrd = en & drv & ~dir_q; PWM_rev = en & drv & dir_q.
//      On shadow load with rev[i]!=dir_q[i]: dir_q<=rev[i], dead counter<=DEAD_CYC-1, go to DEAD.
//    DEAD: both outputs 0, rev_busy=1; the dead counter decrements each clock.
//      At 0, return to DRIVE, with dead time covering cnt 0..DEAD_CYC-1 of the new period.
//      The first drive period after a reversal is therefore high for cnt in [DEAD_CYC, spd_q-1];
//      if spd_q <= DEAD_CYC it stays low for that whole period.
//  - PWM_frwrd[i] and PWM_rev[i] are never high in the same cycle, in any state or input combination.
//  - en low: outputs go 0 on the next clock; FSM, dead counter and shadow loads continue unaffected.
//  - Simultaneous reversal on several channels: each FSM is independent; rev_busy asserts only on changed channels.
//  - Reversal request toggled back before the load edge: no reversal, no dead time.
//  - rst mid-period or mid-DEAD: everything returns to the reset state; dead time is not resumed.
// TESTING (NUM_CH=2, PWM_W=11, DEAD_CYC=32)
//  1. en=1, spd0=spd1=0x00F, rev=0 -> PWM_frwrd high 15 clocks per 2048-clock period; PWM_rev=0.
//  2. Forward at 0x0FF, then rev=2'b11 -> both channels rev_busy for clocks 0..31 of the next period;
//     PWM_rev high 223 clocks in that period, then 255 per period; no overlap cycle.
//  3. spd0 0x0FF->0x010 at cnt=0x080 -> current period stays 255 high; next period 16 high.
//  4. spd0=0x7FF, spd1=0x000 -> ch0 high 2047/2048 clocks; ch1 never high; period_start every 2048 clocks.
//  5. rev=2'b01 from forward with en dropped mid-DEAD -> rev_busy[0] only; all outputs 0 while en=0;
//     ch1 unaffected once en returns.
//  6. Assert rst while PWM_rev[1] high in DEAD/DRIVE -> outputs 0 with no clock edge; after release
//     cnt=0, forward, spd_q=0 until next load.

Source files
------------

// File: rtl/mtr_drv_nch_if.sv
// Bundle of the mtr_drv_nch control inputs and bridge-leg outputs.
// Clock and reset stay as plain ports on the driver.
interface mtr_drv_nch_if #(
  parameter int NUM_CH = 2,
  parameter int PWM_W  = 11
);
  logic                      en;
  logic [NUM_CH*PWM_W-1:0]   spd;
  logic [NUM_CH-1:0]         rev;
  logic [NUM_CH-1:0]         PWM_frwrd;
  logic [NUM_CH-1:0]         PWM_rev;
  logic [NUM_CH-1:0]         rev_busy;
  logic                      period_start;

  modport master (
    output en, spd, rev,
    input  PWM_frwrd, PWM_rev, rev_busy, period_start
  );

  modport slave (
    input  en, spd, rev,
    output PWM_frwrd, PWM_rev, rev_busy, period_start
  );
endinterface

// File: rtl/mtr_drv_nch.sv
// N-channel H-bridge PWM driver: shared PWM counter, double-buffered duty/direction
// and a per-channel dead-time FSM that keeps both legs low after a reversal.
//
// state | meaning
// DRIVE | legs follow duty compare, leg chosen by dir_q
// DEAD  | both legs low after a reversal, dead counter running
module mtr_drv_nch #(
  parameter int NUM_CH   = 2,
  parameter int PWM_W    = 11,
  parameter int DEAD_CYC = 32
) (
  input  logic            clk,
  input  logic            rst,
  mtr_drv_nch_if.slave    bus
);

  localparam logic [PWM_W-1:0] CNT_MAX   = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] DEAD_INIT = PWM_W'(DEAD_CYC - 1);

  typedef enum logic {DRIVE, DEAD} state_t;

  logic [PWM_W-1:0]  cnt;
  logic [PWM_W-1:0]  spd_q    [NUM_CH];
  logic [PWM_W-1:0]  dead_cnt [NUM_CH];
  logic [NUM_CH-1:0] dir_q;
  state_t            st       [NUM_CH];
  logic              load;

  assign load = (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt              <= '0;
      dir_q            <= '0;
      bus.period_start <= 1'b0;
      bus.PWM_frwrd    <= '0;
      bus.PWM_rev      <= '0;
      bus.rev_busy     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        spd_q[i]    <= '0;
        dead_cnt[i] <= '0;
        st[i]       <= DRIVE;
      end
    end else begin
      cnt              <= cnt + 1'b1;
      bus.period_start <= load;
      for (int i = 0; i < NUM_CH; i++) begin
        if (load)
          spd_q[i] <= bus.spd[i*PWM_W +: PWM_W];

        if (st[i] == DEAD) begin
          bus.PWM_frwrd[i] <= 1'b0;
          bus.PWM_rev[i]   <= 1'b0;
          if (dead_cnt[i] == '0) begin
            st[i]           <= DRIVE;
            bus.rev_busy[i] <= 1'b0;
          end else begin
            dead_cnt[i]     <= dead_cnt[i] - 1'b1;
            bus.rev_busy[i] <= 1'b1;
          end
        end else if (load && (bus.rev[i] != dir_q[i])) begin
          // Legs are cleared on the same edge dir_q flips, so no overlap cycle can occur.
          dir_q[i]         <= bus.rev[i];
          dead_cnt[i]      <= DEAD_INIT;
          st[i]            <= DEAD;
          bus.PWM_frwrd[i] <= 1'b0;
          bus.PWM_rev[i]   <= 1'b0;
          bus.rev_busy[i]  <= 1'b1;
        end else begin
          bus.PWM_frwrd[i] <= bus.en & (cnt < spd_q[i]) & ~dir_q[i];
          bus.PWM_rev[i]   <= bus.en & (cnt < spd_q[i]) &  dir_q[i];
          bus.rev_busy[i]  <= 1'b0;
        end
      end
    end
  end

endmodule
